// File: rtl/dna_search_pkg.sv
// Shared sizing and types for the brute-force DNA substring search engine.
package dna_search_pkg;

  localparam int DATA_W  = 1024;  // reference width in bits
  localparam int KEY_W   = 64;    // key width in bits
  localparam int BASE_W  = 2;     // bits per nucleotide
  localparam int NUM_CMP = 4;     // windows compared per clock

  // Number of base-aligned window positions and the width needed to name one.
  localparam int NUM_POS = (DATA_W - KEY_W) / BASE_W + 1;
  localparam int POS_W   = $clog2(NUM_POS);

  // Width of a bit-shift amount that can reach any window inside the reference.
  localparam int SH_W    = $clog2(DATA_W);

  // Nucleotide encoding and position type.
  typedef logic [BASE_W-1:0] base_t;
  typedef logic [POS_W-1:0]  pos_t;

  // Base of the last group; a miss there ends the search.
  localparam pos_t LAST_BASE = POS_W'(((NUM_POS - 1) / NUM_CMP) * NUM_CMP);

endpackage

// File: rtl/key_window_cmp.sv
// One window-versus-key equality comparator; masked-off windows never hit.
module key_window_cmp
  import dna_search_pkg::*;
(
  input  logic [KEY_W-1:0] window,
  input  logic [KEY_W-1:0] key,
  input  logic             valid,
  output logic             hit
);

  // A hit needs a real position and an exact match across all key bases.
  always_comb begin
    hit = valid && (window == key);
  end

endmodule

// File: rtl/search_4comparators.sv
// Per-block match engine: slides the key across the reference NUM_CMP base
// positions per clock and latches the first (lowest) matching position.
module search_4comparators
  import dna_search_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] data,
  input  logic [KEY_W-1:0]  key,
  output logic              match,
  output logic              done,
  output logic [POS_W-1:0]  match_pos
);

  pos_t               base_q, base_d;
  logic               match_q, match_d;
  logic               done_q, done_d;
  pos_t               match_pos_q, match_pos_d;
  logic [NUM_CMP-1:0] hit;
  logic               any_hit;
  pos_t               first_pos;

  // Window mux and comparator for each position base+gi of the current group.
  // Base 0 sits at the top of data, so the window at p is the KEY_W bits left
  // after shifting data right by (DATA_W-KEY_W) - BASE_W*p.
  generate
    for (genvar gi = 0; gi < NUM_CMP; gi++) begin : g_cmp
      pos_t             pos;
      pos_t             pos_eff;
      logic             valid;
      logic [SH_W-1:0]  shamt;
      logic [KEY_W-1:0] window;

      assign pos     = base_q + POS_W'(gi);
      assign valid   = pos < POS_W'(NUM_POS);
      // Masked positions would run past the end of data; steer them to p=0.
      assign pos_eff = valid ? pos : '0;
      assign shamt   = SH_W'(DATA_W - KEY_W) - SH_W'(pos_eff) * SH_W'(BASE_W);
      assign window  = KEY_W'(data >> shamt);

      key_window_cmp u_cmp (
        .window (window),
        .key    (key),
        .valid  (valid),
        .hit    (hit[gi])
      );
    end
  endgenerate

  // Priority encoder: the lowest matching position in the group wins.
  always_comb begin
    any_hit   = 1'b0;
    first_pos = base_q;
    for (int i = NUM_CMP - 1; i >= 0; i--) begin
      if (hit[i]) begin
        any_hit   = 1'b1;
        first_pos = base_q + POS_W'(i);
      end
    end
  end

  // Next state: latch a hit, finish on the last group, else advance a group.
  always_comb begin
    base_d      = base_q;
    match_d     = match_q;
    done_d      = done_q;
    match_pos_d = match_pos_q;
    if (!done_q) begin
      if (any_hit) begin
        match_d     = 1'b1;
        done_d      = 1'b1;
        match_pos_d = first_pos;
      end else if (base_q >= LAST_BASE) begin
        done_d = 1'b1;
      end else begin
        base_d = base_q + POS_W'(NUM_CMP);
      end
    end
  end

  // State and output registers; reset clears everything without a clock.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      base_q      <= '0;
      match_q     <= 1'b0;
      done_q      <= 1'b0;
      match_pos_q <= '0;
    end else begin
      base_q      <= base_d;
      match_q     <= match_d;
      done_q      <= done_d;
      match_pos_q <= match_pos_d;
    end
  end

  assign match     = match_q;
  assign done      = done_q;
  assign match_pos = match_pos_q;

endmodule

// File: tb/tb_search_4comparators.sv
// Self-checking bench for search_4comparators: a scan-the-string reference
// model predicts the edge, flag and position of the first hit for each search.
module tb_search_4comparators;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [1023:0] data  = '0;
  logic [63:0]   key   = '0;
  logic          match;
  logic          done;
  logic [8:0]    match_pos;

  int checks   = 0;
  int failures = 0;
  int edge_cnt = 0;
  int exp_edge = 121;
  bit exp_match = 1'b0;
  int exp_pos  = 0;

  search_4comparators dut (
    .clock     (clock),
    .reset     (reset),
    .data      (data),
    .key       (key),
    .match     (match),
    .done      (done),
    .match_pos (match_pos)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (edge %0d)", name, act, req, edge_cnt);
    end
  endtask

  // Reference: scan every base-aligned window from p=0 upward.
  task automatic model(input logic [1023:0] d, input logic [63:0] k,
                       output int e, output bit m, output int p);
    e = 121;
    m = 1'b0;
    p = 0;
    for (int q = 0; q < 481; q++) begin
      if (d[1023 - 2*q -: 64] == k) begin
        e = q / 4 + 1;
        m = 1'b1;
        p = q;
        break;
      end
    end
  endtask

  function automatic logic [1023:0] place(input logic [1023:0] d, input logic [63:0] k, input int p);
    logic [1023:0] r;
    r = d;
    r[1023 - 2*p -: 64] = k;
    return r;
  endfunction

  function automatic logic [1023:0] rand_data();
    logic [1023:0] r;
    for (int w = 0; w < 32; w++) r[w*32 +: 32] = $urandom();
    return r;
  endfunction

  // Expected outputs from the model given reset level and edges since release.
  task automatic compare_outputs();
    bit hit;
    hit = reset && (edge_cnt >= exp_edge);
    check("match", match, hit && exp_match);
    check("done", done, hit);
    check("match_pos", match_pos, (hit && exp_match) ? exp_pos : 0);
  endtask

  // One rising edge, then compare shortly after it.
  task automatic step();
    @(posedge clock);
    if (reset) edge_cnt++;
    #1;
    compare_outputs();
  endtask

  // Hold reset, load operands, check cleared state, release at a negedge.
  task automatic start(input logic [1023:0] d, input logic [63:0] k);
    reset = 1'b0;
    data  = d;
    key   = k;
    model(d, k, exp_edge, exp_match, exp_pos);
    edge_cnt = 0;
    @(negedge clock);
    compare_outputs();
    reset = 1'b1;
  endtask

  // Drop reset mid-cycle and confirm outputs clear before any clock edge.
  task automatic async_pulse();
    #2;
    reset = 1'b0;
    #1;
    edge_cnt = 0;
    compare_outputs();
  endtask

  initial begin
    logic [1023:0] d;
    logic [63:0]   k;

    // Match at p=0, visible at the very first edge.
    d = rand_data();
    k = d[1023:960];
    start(d, k);
    check("m0_model_edge", exp_edge, 1);
    step();
    check("p0_match", match, 1);
    check("p0_pos", match_pos, 0);
    repeat (3) step();

    // Match at p=6: nothing at edge 1, found at edge 2.
    d = rand_data();
    k = {$urandom(), $urandom()};
    d = place(d, k, 6);
    start(d, k);
    check("p6_model_pos", exp_pos, 6);
    step();
    check("p6_e1_done", done, 0);
    step();
    check("p6_e2_pos", match_pos, 6);
    repeat (3) step();

    // Match only at the last position p=480.
    d = '0;
    k = 64'hFFFF_FFFF_FFFF_FFFF;
    d[63:0] = k;
    start(d, k);
    check("p480_model_edge", exp_edge, 121);
    repeat (124) step();
    check("p480_pos", match_pos, 480);

    // No match anywhere: done exactly at edge 121.
    d = '0;
    start(d, k);
    check("none_model_match", exp_match, 0);
    repeat (124) step();
    check("none_done", done, 1);

    // Key only at an odd bit offset never matches.
    d = rand_data();
    k = d[1022:959];
    start(d, k);
    check("odd_model_match", exp_match, 0);
    repeat (124) step();
    check("odd_match", match, 0);

    // Overlapping hits at p=5 and p=7: the lower one wins at edge 2.
    d = rand_data();
    k = 64'h6666_6666_6666_6666;
    d = place(d, k, 7);
    d = place(d, k, 5);
    d[1023 - 2*3 -: 2] = 2'b11;
    d[1023 - 2*4 -: 2] = 2'b11;
    start(d, k);
    check("p57_model_pos", exp_pos, 5);
    check("p57_model_edge", exp_edge, 2);
    repeat (4) step();

    // Reset pulsed at edge 50 of a miss: clear at once, restart from p=0.
    d = '0;
    k = 64'hFFFF_FFFF_FFFF_FFFF;
    start(d, k);
    repeat (50) step();
    async_pulse();
    @(negedge clock);
    reset = 1'b1;
    repeat (120) step();
    check("pulse_e120_done", done, 0);
    repeat (3) step();

    // Randomized searches, each ended by an asynchronous mid-cycle reset.
    for (int n = 0; n < 16; n++) begin
      d = rand_data();
      k = {$urandom(), $urandom()};
      if ($urandom_range(0, 2) != 0) d = place(d, k, $urandom_range(0, 480));
      start(d, k);
      repeat (exp_edge + 2) step();
      check("rnd_done", done, 1);
      async_pulse();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
